// File: rtl/sum_result_buffer.sv
// Captures changed values of the adder result bus into a timestamped FIFO drained by a
// valid/ready reader; also keeps a running total and a drop counter.
module sum_result_buffer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           sum_in,
    input  logic                       sample_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TS_W-1:0]            out_ts,
    output logic [$clog2(DEPTH):0]     level,
    output logic [WIDTH+7:0]           acc_total,
    output logic [7:0]                 drop_cnt,
    output logic                       overflow
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned LW   = AW + 1;
    localparam int unsigned ACCW = WIDTH + 8;

    typedef enum logic [1:0] {StEmpty, StPart, StFull} state_e;

    state_e            state_q, state_d;
    logic [LW-1:0]     level_q, level_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [TS_W-1:0]   ts_q;
    logic [WIDTH-1:0]  last_q;
    logic              armed_q;
    logic [ACCW-1:0]   acc_q;
    logic [7:0]        drop_q;
    logic              ovf_q;

    logic [WIDTH-1:0]  mem_data [DEPTH];
    logic [TS_W-1:0]   mem_ts   [DEPTH];

    logic cap, push, pop, full, push_ok, drop;

    assign cap     = sample_en & (armed_q | (sum_in != last_q));
    assign push    = cap & ~clear;
    assign pop     = (state_q != StEmpty) & out_ready & ~clear;
    assign full    = (state_q == StFull);
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign push_ok = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        if (clear) begin
            state_d = StEmpty;
            level_d = '0;
        end else begin
            level_d = level_q + LW'(push_ok) - LW'(pop);
            unique case (state_q)
                StEmpty: if (push_ok) state_d = StPart;
                StPart: begin
                    if (level_d == LW'(DEPTH)) state_d = StFull;
                    else if (level_d == '0)    state_d = StEmpty;
                end
                StFull:  if (pop && !push_ok) state_d = StPart;
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StEmpty;
            level_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            if (clear) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_data[wr_ptr_q] <= sum_in;
            mem_ts[wr_ptr_q]   <= ts_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q    <= '0;
            last_q  <= '0;
            armed_q <= 1'b1;
            acc_q   <= '0;
            drop_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
            if (sample_en) last_q <= sum_in;
            if (clear)          armed_q <= 1'b1;
            else if (sample_en) armed_q <= 1'b0;
            if (clear) begin
                acc_q  <= '0;
                drop_q <= '0;
                ovf_q  <= 1'b0;
            end else begin
                // Dropped captures still count towards the total.
                if (cap) acc_q <= acc_q + ACCW'(sum_in);
                if (drop) begin
                    ovf_q <= 1'b1;
                    if (drop_q != 8'hff) drop_q <= drop_q + 8'd1;
                end
            end
        end
    end

    assign out_valid = (state_q != StEmpty);
    assign out_data  = out_valid ? mem_data[rd_ptr_q] : '0;
    assign out_ts    = out_valid ? mem_ts[rd_ptr_q] : '0;
    assign level     = level_q;
    assign acc_total = acc_q;
    assign drop_cnt  = drop_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_sum_result_buffer.sv
// Self-checking bench: directed scenarios plus random traffic, compared every cycle against a
// queue-based model of the capture/FIFO/total rules.
module tb_sum_result_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] sum_in = '0;
    logic        sample_en = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_data;
    logic [15:0] out_ts;
    logic [3:0]  level;
    logic [23:0] acc_total;
    logic [7:0]  drop_cnt;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    sum_result_buffer #(.WIDTH(16), .DEPTH(DEPTH), .TS_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .sum_in(sum_in), .sample_en(sample_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ts(out_ts),
        .level(level), .acc_total(acc_total), .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Behavioural model: queue of {data, ts}.
    logic [31:0] m_q[$];
    logic [15:0] m_last = '0;
    bit          m_armed = 1'b1;
    logic [15:0] m_ts = '0;
    logic [23:0] m_acc = '0;
    int          m_drop = 0;
    bit          m_ovf = 1'b0;

    logic [31:0] popped[$];
    bit          collect = 1'b0;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_last  = '0;
        m_armed = 1'b1;
        m_ts    = '0;
        m_acc   = '0;
        m_drop  = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step();
        bit cap;
        cap = sample_en && (m_armed || sum_in != m_last);
        if (clear) begin
            m_q.delete();
            m_acc  = '0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            if (out_ready && m_q.size() > 0) void'(m_q.pop_front());
            if (cap) begin
                m_acc = m_acc + 24'(sum_in);
                if (m_q.size() < DEPTH) m_q.push_back({sum_in, m_ts});
                else begin
                    if (m_drop < 255) m_drop++;
                    m_ovf = 1'b1;
                end
            end
        end
        if (sample_en) begin
            m_last  = sum_in;
            m_armed = 1'b0;
        end
        if (clear) m_armed = 1'b1;
        m_ts = m_ts + 16'd1;
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    // Pop collector: sees pre-edge outputs.
    initial forever begin
        @(posedge clk);
        if (collect && rst_n && out_valid && out_ready) popped.push_back({out_data, out_ts});
    end

    initial forever begin
        @(posedge clk);
        #1;
        check("out_valid", out_valid, m_q.size() > 0);
        check("level", level, m_q.size());
        if (m_q.size() > 0) begin
            check("out_data", out_data, m_q[0][31:16]);
            check("out_ts", out_ts, m_q[0][15:0]);
        end
        check("acc_total", acc_total, m_acc);
        check("drop_cnt", drop_cnt, m_drop);
        check("overflow", overflow, m_ovf);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sample(input logic [15:0] v);
        sample_en = 1'b1;
        sum_in = v;
        tick();
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_level", level, 0);
        check("rst_valid", out_valid, 0);
        check("rst_acc", acc_total, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_ovf", overflow, 0);

        // T1: first sample after reset is captured with ts 0; repeats add nothing
        rst_n = 1'b1;
        sample(16'd0);
        check("t1_level", level, 1);
        check("t1_data", out_data, 0);
        check("t1_ts", out_ts, 0);
        sample(16'd0);
        sample(16'd0);
        check("t1_level_hold", level, 1);

        // T2: 0,1,1,3 with reader always ready
        sample_en = 1'b0; clear = 1'b1; out_ready = 1'b1;
        tick();
        clear = 1'b0;
        popped.delete();
        collect = 1'b1;
        sample(16'd0); sample(16'd1); sample(16'd1); sample(16'd3);
        sample_en = 1'b0;
        tick(); tick();
        collect = 1'b0;
        check("t2_count", popped.size(), 3);
        if (popped.size() == 3) begin
            check("t2_d0", popped[0][31:16], 0);
            check("t2_d1", popped[1][31:16], 1);
            check("t2_d2", popped[2][31:16], 3);
            check("t2_ts_inc", (popped[1][15:0] > popped[0][15:0]) &&
                               (popped[2][15:0] > popped[1][15:0]), 1);
        end
        check("t2_acc", acc_total, 4);

        // T3: fill past full with reader stalled
        clear = 1'b1; out_ready = 1'b0;
        tick();
        clear = 1'b0;
        for (int i = 0; i < DEPTH + 3; i++) sample(16'(10 + i));
        sample_en = 1'b0;
        tick();
        check("t3_level", level, DEPTH);
        check("t3_drop", drop_cnt, 3);
        check("t3_ovf", overflow, 1);
        check("t3_acc", acc_total, 165);

        // T4: full, pop and new value in the same cycle
        popped.delete();
        collect = 1'b1;
        out_ready = 1'b1;
        sample(16'd100);
        check("t4_level", level, DEPTH);
        check("t4_drop", drop_cnt, 3);
        sample_en = 1'b0;
        repeat (10) tick();
        collect = 1'b0;
        check("t3_drain_count", popped.size(), DEPTH + 1);
        if (popped.size() == DEPTH + 1) begin
            for (int i = 0; i < DEPTH; i++) check("t3_drain", popped[i][31:16], 10 + i);
            check("t4_last", popped[DEPTH][31:16], 100);
        end

        // T5: clear with entries held and a capture pending
        clear = 1'b1;
        tick();
        clear = 1'b0; out_ready = 1'b0;
        sample(16'd5); sample(16'd6); sample(16'd7);
        check("t5_level_pre", level, 3);
        clear = 1'b1;
        sample(16'd9);
        check("t5_level", level, 0);
        check("t5_valid", out_valid, 0);
        check("t5_acc", acc_total, 0);
        clear = 1'b0;
        sample(16'd9);
        check("t5_rearm_level", level, 1);
        check("t5_rearm_data", out_data, 9);
        check("t5_rearm_acc", acc_total, 9);

        // T6: asynchronous reset in the middle of a drain
        sample(16'd20); sample(16'd21); sample(16'd22);
        sample_en = 1'b0; out_ready = 1'b1;
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_level", level, 0);
        check("t6_data", out_data, 0);
        check("t6_acc", acc_total, 0);
        check("t6_drop", drop_cnt, 0);
        tick();
        rst_n = 1'b1; out_ready = 1'b0;
        sample(16'h55);
        check("t6_ts", out_ts, 0);
        check("t6_data_after", out_data, 16'h55);
        check("t6_level_after", level, 1);

        // Random traffic with varying backpressure
        for (int phase = 0; phase < 4; phase++) begin
            for (int c = 0; c < 800; c++) begin
                clear = ($urandom_range(0, 79) == 0);
                sample_en = ($urandom_range(0, 3) != 0);
                sum_in = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 5));
                case (phase)
                    0: out_ready = ($urandom_range(0, 3) == 0);
                    1: out_ready = ($urandom_range(0, 3) != 0);
                    2: out_ready = ($urandom_range(0, 9) == 0);
                    default: out_ready = $urandom_range(0, 1) == 1;
                endcase
                tick();
            end
        end

        clear = 1'b0; sample_en = 1'b0; out_ready = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
